// File: rtl/sequential_divider_if.sv
// Handshake and operand/result bundle for the sequential divider.
// The master issues divisions; the slave is the divider itself.
interface sequential_divider_if #(
  parameter int L_WORD = 4
);
  logic              start;
  logic [L_WORD-1:0] dividend;
  logic [L_WORD-1:0] divisor;
  logic [L_WORD-1:0] quotient;
  logic [L_WORD-1:0] remainder;
  logic              Ready;
  logic              done;
  logic              div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, Ready, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, Ready, done, div_by_zero
  );
endinterface

// File: rtl/sequential_divider.sv
// Unsigned restoring shift-subtract divider, one quotient bit per SHIFT/SUB pair.
// Datapath and controller share one register block; results hold until the next finish.
module sequential_divider #(
  parameter int L_WORD = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  sequential_divider_if.slave   bus
);

  localparam int CW = $clog2(L_WORD + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(L_WORD);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_SUB   = 3'd3;
  localparam logic [2:0] S_LATCH = 3'd4;
  localparam logic [2:0] S_DZ    = 3'd5;

  logic [2:0]        r_state;
  logic [L_WORD-1:0] r_q;
  logic [L_WORD:0]   r_a;
  logic [L_WORD-1:0] r_d;
  logic [CW-1:0]     r_cnt;
  logic [L_WORD-1:0] r_quotient;
  logic [L_WORD-1:0] r_remainder;
  logic              r_done;
  logic              r_div_by_zero;

  logic [L_WORD:0]   w_d_ext;
  logic              w_a_ge_d;
  logic [L_WORD:0]   w_a_minus_d;
  logic              w_d_zero;

  // A carries one extra bit so the shifted partial remainder (< 2*D) never overflows.
  assign w_d_ext     = {1'b0, r_d};
  assign w_a_ge_d    = (r_a >= w_d_ext);
  assign w_a_minus_d = r_a - w_d_ext;
  assign w_d_zero    = (r_d == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_q           <= '0;
      r_a           <= '0;
      r_d           <= '0;
      r_cnt         <= '0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_done        <= 1'b0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_q     <= bus.dividend;
            r_d     <= bus.divisor;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          r_a           <= '0;
          r_cnt         <= CNT_INIT;
          r_div_by_zero <= 1'b0;
          r_state       <= w_d_zero ? S_DZ : S_SHIFT;
        end
        S_SHIFT: begin
          {r_a, r_q} <= {r_a, r_q} << 1;
          r_state    <= S_SUB;
        end
        S_SUB: begin
          if (w_a_ge_d) begin
            r_a    <= w_a_minus_d;
            r_q[0] <= 1'b1;
          end
          r_cnt   <= r_cnt - CNT_LAST;
          r_state <= (r_cnt == CNT_LAST) ? S_LATCH : S_SHIFT;
        end
        S_LATCH: begin
          r_quotient  <= r_q;
          r_remainder <= r_a[L_WORD-1:0];
          r_done      <= 1'b1;
          r_state     <= S_IDLE;
        end
        S_DZ: begin
          // Q still holds the untouched dividend, which becomes the remainder.
          r_quotient    <= '1;
          r_remainder   <= r_q;
          r_div_by_zero <= 1'b1;
          r_done        <= 1'b1;
          r_state       <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.Ready       = (r_state == S_IDLE);
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_div_by_zero;

endmodule
